// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (serial_add now, serial_sub later).
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_full_add.sv
// One-bit full adder built from two half adders and an OR gate,
// mirroring the structure of the training full subtractor.
module half_add (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module full_add (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_add u_ha0 (.i_a(A),    .i_b(B),   .o_s(w_s1), .o_c(w_c1));
  half_add u_ha1 (.i_a(w_s1), .i_b(Cin), .o_s(S),    .o_c(w_c2));

  assign Cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, LSB first,
// wrapped in a start/busy/done handshake with results held until the next add.
module serial_add
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_shS;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cMsb;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_c;

  full_add u_fa (
    .A   (r_shA[0]),
    .B   (r_shB[0]),
    .Cin (r_carry),
    .S   (w_s),
    .Cout(w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shA   <= '0;
      r_shB   <= '0;
      r_shS   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cMsb  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a new start directly so back-to-back adds lose no cycle.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_shA   <= a;
            r_shB   <= b;
            r_shS   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_shS   <= {w_s, r_shS[WIDTH-1:1]};
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_carry <= w_c;
          if (r_cnt == PENULT) begin
            r_cMsb <= w_c;
          end
          if (r_cnt == LAST) begin
            r_sum   <= {w_s, r_shS[WIDTH-1:1]};
            r_cout  <= w_c;
            r_ovf   <= w_c ^ r_cMsb;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add at WIDTH=8 and WIDTH=16, compared against
// plain integer addition and a sign-rule overflow model.
module tb_serial_add;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Reference: true sum plus the classic "same-sign operands, different-sign result" overflow rule.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t};
  endfunction

  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  // Called at a falling edge; start is seen on the next rising edge, and on return
  // we sit at the falling edge just after the capture with fresh junk on the operands.
  task automatic do_start8(input logic [7:0] x, input logic [7:0] y, input logic c);
    start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic do_start16(input logic [15:0] x, input logic [15:0] y, input logic c);
    start16 = 1'b1; a16 = x; b16 = y; cin16 = c;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
  endtask

  task automatic wait_done(input bit wide, output int lat, output int busyN);
    lat = 0;
    busyN = 0;
    while ((wide ? done16 : done8) !== 1'b1 && lat < 64) begin
      if ((wide ? busy16 : busy8) === 1'b1) busyN++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nChecks++; if (busy8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got=%b want=0", busy8); end
    nChecks++; if (done8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got=%b want=0", done8); end
    nChecks++; if (sum8 !== 8'h00) begin nFails++; $display("[TB] FAIL reset_sum got=%h want=00", sum8); end
    nChecks++; if (cout8 !== 1'b0 || ovf8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags got cout=%b ovf=%b want 0/0", cout8, ovf8); end
    nChecks++; if ({busy16, done16, sum16, cout16, ovf16} !== 20'd0) begin nFails++; $display("[TB] FAIL reset_w16 got busy=%b done=%b sum=%h", busy16, done16, sum16); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, busyN;
    do_start8(8'h35, 8'h4A, 1'b0);
    wait_done(1'b0, lat, busyN);
    nChecks++; if (done8 !== 1'b1 || lat != 8) begin nFails++; $display("[TB] FAIL basic_latency got=%0d want=8", lat); end
    nChecks++; if (busyN != 8) begin nFails++; $display("[TB] FAIL basic_busy_cycles got=%0d want=8", busyN); end
    nChecks++; if (busy8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_in_done got=%b want=0", busy8); end
    nChecks++; if ({cout8, ovf8, sum8} !== {2'b00, 8'h7F}) begin nFails++; $display("[TB] FAIL basic_result got sum=%h cout=%b ovf=%b want 7f/0/0", sum8, cout8, ovf8); end
    @(negedge clk);
    nChecks++; if (done8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_one_cycle got=%b want=0", done8); end
    nChecks++; if (sum8 !== 8'h7F) begin nFails++; $display("[TB] FAIL basic_hold got=%h want=7f", sum8); end
  endtask

  task automatic test_carry_ovf;
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] want [3] = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}, {1'b0, 1'b0, 8'h01}};
    int lat, busyN;
    for (int i = 0; i < 3; i++) begin
      do_start8(va[i], vb[i], vc[i]);
      wait_done(1'b0, lat, busyN);
      nChecks++;
      if (done8 !== 1'b1 || {ovf8, cout8, sum8} !== want[i]) begin
        nFails++;
        $display("[TB] FAIL edge_case_%0d got ovf=%b cout=%b sum=%h want=%h", i, ovf8, cout8, sum8, want[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int nDone = 0;
    logic [7:0] seen = 8'h00;
    do_start8(8'h10, 8'h20, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      if (i == 3) begin start8 = 1'b0; end
      if (done8 === 1'b1) begin nDone++; seen = sum8; end
      @(negedge clk);
    end
    nChecks++; if (nDone != 1) begin nFails++; $display("[TB] FAIL ignore_done_count got=%0d want=1", nDone); end
    nChecks++; if (seen !== 8'h30 || sum8 !== 8'h30) begin nFails++; $display("[TB] FAIL ignore_result got=%h/%h want=30", seen, sum8); end
  endtask

  task automatic test_back_to_back;
    int lat, busyN;
    do_start8(8'h12, 8'h34, 1'b0);
    wait_done(1'b0, lat, busyN);
    nChecks++; if (done8 !== 1'b1 || sum8 !== 8'h46) begin nFails++; $display("[TB] FAIL b2b_first got=%h want=46", sum8); end
    do_start8(8'h80, 8'h80, 1'b0);
    nChecks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_no_gap got busy=%b done=%b want 1/0", busy8, done8); end
    repeat (4) @(negedge clk);
    nChecks++; if ({cout8, ovf8, sum8} !== {2'b00, 8'h46}) begin nFails++; $display("[TB] FAIL b2b_hold got sum=%h cout=%b ovf=%b want 46/0/0", sum8, cout8, ovf8); end
    wait_done(1'b0, lat, busyN);
    nChecks++; if (done8 !== 1'b1 || lat != 4) begin nFails++; $display("[TB] FAIL b2b_latency got=%0d want=4", lat); end
    nChecks++; if ({cout8, ovf8, sum8} !== {2'b11, 8'h00}) begin nFails++; $display("[TB] FAIL b2b_second got sum=%h cout=%b ovf=%b want 00/1/1", sum8, cout8, ovf8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nDone = 0;
    int lat, busyN;
    do_start8(8'hC3, 8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nChecks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      nFails++;
      $display("[TB] FAIL midreset_clear got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy8, done8, sum8, cout8, ovf8);
    end
    for (int i = 0; i < 16; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) nDone++;
      @(negedge clk);
    end
    nChecks++; if (nDone != 0) begin nFails++; $display("[TB] FAIL midreset_ghost got=%0d want=0", nDone); end
    do_start8(8'h21, 8'h43, 1'b0);
    wait_done(1'b0, lat, busyN);
    nChecks++; if (done8 !== 1'b1 || sum8 !== 8'h64 || cout8 !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_fresh got=%h want=64", sum8); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, busyN;
    logic [7:0]  x8, y8;
    logic [15:0] x16, y16;
    logic        c;
    logic [9:0]  e8;
    logic [17:0] e16;
    for (int i = 0; i < 1000; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); c = 1'($urandom);
      e8 = ref8(x8, y8, c);
      do_start8(x8, y8, c);
      wait_done(1'b0, lat, busyN);
      nChecks++;
      if (done8 !== 1'b1 || lat != 8 || {ovf8, cout8, sum8} !== e8) begin
        nFails++;
        $display("[TB] FAIL rand8 a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h lat=%0d want=%h", x8, y8, c, ovf8, cout8, sum8, lat, e8);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      x16 = 16'($urandom); y16 = 16'($urandom); c = 1'($urandom);
      if (i < 4) begin x16 = (i < 2) ? 16'hFFFF : 16'h7FFF; y16 = (i[0]) ? 16'h8000 : 16'h0001; end
      e16 = ref16(x16, y16, c);
      do_start16(x16, y16, c);
      wait_done(1'b1, lat, busyN);
      nChecks++;
      if (done16 !== 1'b1 || lat != 16 || busyN != 16 || {ovf16, cout16, sum16} !== e16) begin
        nFails++;
        $display("[TB] FAIL rand16 a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h lat=%0d want=%h", x16, y16, c, ovf16, cout16, sum16, lat, e16);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_carry_ovf;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Bit-serial N-bit adder. It is the additive counterpart of the training full-subtractor.
- It reuses a single full-adder cell plus one carry flip-flop. It processes one bit per clock, LSB first.
- A start/busy/done handshake wraps the operation. This lets board-level training tops drive it from switches or buttons and show the result on LEDs or 7-segment displays.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  request; sampled only when busy=0
a  in  WIDTH  augend, captured on the accepted start edge
b  in  WIDTH  addend, captured on the accepted start edge
cin  in  1  carry-in, captured on the accepted start edge
busy  out  1  high while the add is in progress
done  out  1  one-cycle pulse when the result becomes valid
sum  out  WIDTH  result, held until the next accepted start
cout  out  1  carry out of the MSB, held with sum
ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB), held with sum

Behaviour:
- Reset: the synchronous reset takes effect on any clock edge with rst_n=0, including mid-operation. Required state after reset:
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0, ovf=0
  - internal shift registers, carry flop and bit counter cleared
  - no partial result survives the reset
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge captures a→shA, b→shB, cin→carry, and sets cnt=0. Next state is RUN; busy=1 from the next cycle.
  - start=0: remain in IDLE.
- RUN, on each edge:
  - The full_add cell computes (shA[0], shB[0], carry) → (s, c).
  - s is shifted into the MSB of the sum shift register. shA and shB shift right by one. carry←c and cnt←cnt+1.
  - When cnt=WIDTH-2 (MSB about to be processed), the incoming carry is recorded as c_msb.
  - On the edge that processes bit WIDTH-1:
    - next state is DONE
    - sum←completed shift register
    - cout←c
    - ovf←c XOR c_msb
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or RUN directly if start=1 on that edge. A back-to-back start is accepted with no dead cycle.
- Latency: an accepted start on edge k gives done=1 in the cycle after edge k+WIDTH, i.e. done is visible WIDTH cycles after busy rises. Throughput is one add per WIDTH+1 cycles.
- start while busy=1 is ignored; operands and the in-flight result are unaffected.
- Outputs sum, cout and ovf change only on the DONE transition or on reset. They are stable at all other times, including during a following RUN.
- Width rules:
  - cnt is $clog2(WIDTH) bits and does not wrap past WIDTH-1.
  - Arithmetic is modulo 2^WIDTH.
  - cout carries bit WIDTH of the true sum.
- Inputs a, b and cin may change freely after the start edge.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH constant
  - the package is reused by a planned serial_sub
- One sub-module, full_add (A, B, Cin → S, Cout):
  - built from two half_add instances plus an OR gate, the same structure as the existing subtractor
  - instantiated once, as the single per-bit datapath cell

Test Plan:
1. WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse → busy high 8 cycles, then done pulse; sum=0x7F, cout=0, ovf=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Then a=0x00, b=0x00, cin=1 → sum=0x01.
3. Start accepted with a=0x10, b=0x20; re-assert start with a=0xFF, b=0xFF at RUN cycle 3 → ignored; result sum=0x30, exactly one done pulse.
4. Back-to-back: start held high through the DONE cycle with new operands 0x80+0x80 → second RUN begins with no IDLE cycle. First result is held during the second RUN; the second done gives sum=0x00, cout=1, ovf=1.
5. rst_n=0 for one edge at RUN cycle 5 → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse ever appears for the aborted add, and a fresh start then completes normally.
6. Random regression: 1000 random a/b/cin vectors at WIDTH=8 and WIDTH=16, checked against the reference {cout,sum}=a+b+cin and the signed-overflow model.
